// File: rtl/char_slot_sched.sv
// Falling-character slot table for the typing game: one sequencer serialises
// spawn, key-hit and per-frame move requests; the renderer reads slots through a side port.
`timescale 1ns/1ps
module char_slot_sched #(
    parameter int NSLOT    = 16,
    parameter int BOTTOM   = 480,
    parameter int MAX_MISS = 8,
    parameter int SCORE_W  = 10,
    localparam int IW      = $clog2(NSLOT)
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               spawn_req,
    input  logic [7:0]         spawn_ascii,
    input  logic [9:0]         spawn_x,
    input  logic [2:0]         spawn_speed,
    output logic               spawn_ack,
    output logic               spawn_ok,
    input  logic               hit_req,
    input  logic [7:0]         hit_ascii,
    output logic               hit_ack,
    output logic               hit_found,
    input  logic [IW-1:0]      rd_idx,
    output logic               rd_valid,
    output logic [7:0]         rd_ascii,
    output logic [9:0]         rd_x,
    output logic [9:0]         rd_y,
    output logic [2:0]         rd_speed,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss_cnt,
    output logic               gameover,
    output logic               tick_drop
);

    typedef enum logic [2:0] {IDLE, MOVE, HIT, SPAWN, COMMIT, ACK} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          op_hit;
    logic          tick_pend;
    logic [7:0]    req_ascii;
    logic [9:0]    req_x;
    logic [2:0]    req_speed;
    logic          cand_found;
    logic [IW-1:0] cand_idx;
    logic [9:0]    cand_y;
    logic          overlap;

    logic       slot_valid [NSLOT];
    logic [7:0] slot_ascii [NSLOT];
    logic [9:0] slot_x     [NSLOT];
    logic [9:0] slot_y     [NSLOT];
    logic [2:0] slot_speed [NSLOT];

    logic [10:0]        ny;
    logic [SCORE_W-1:0] score_inc;
    logic [SCORE_W-1:0] miss_inc;
    logic               spawn_fits;

    // Move arithmetic is done in 11 bits so a character near row 1023 cannot wrap back on screen.
    assign ny         = {1'b0, slot_y[idx]} + {8'd0, slot_speed[idx]};
    assign score_inc  = (score == '1) ? score : score + SCORE_W'(1);
    assign miss_inc   = (miss_cnt == '1) ? miss_cnt : miss_cnt + SCORE_W'(1);
    assign spawn_fits = cand_found && !overlap;

    assign rd_valid = slot_valid[rd_idx];
    assign rd_ascii = slot_ascii[rd_idx];
    assign rd_x     = slot_x[rd_idx];
    assign rd_y     = slot_y[rd_idx];
    assign rd_speed = slot_speed[rd_idx];

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            op_hit     <= 1'b0;
            tick_pend  <= 1'b0;
            req_ascii  <= '0;
            req_x      <= '0;
            req_speed  <= '0;
            cand_found <= 1'b0;
            cand_idx   <= '0;
            cand_y     <= '0;
            overlap    <= 1'b0;
            spawn_ack  <= 1'b0;
            spawn_ok   <= 1'b0;
            hit_ack    <= 1'b0;
            hit_found  <= 1'b0;
            score      <= '0;
            miss_cnt   <= '0;
            gameover   <= 1'b0;
            tick_drop  <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_valid[i] <= 1'b0;
                slot_ascii[i] <= '0;
                slot_x[i]     <= '0;
                slot_y[i]     <= '0;
                slot_speed[i] <= '0;
            end
        end else begin
            spawn_ack <= 1'b0;
            hit_ack   <= 1'b0;
            if (frame_tick && tick_pend) tick_drop <= 1'b1;
            if (frame_tick) tick_pend <= 1'b1;

            case (state)
                IDLE: begin
                    idx        <= '0;
                    cand_found <= 1'b0;
                    cand_idx   <= '0;
                    cand_y     <= '0;
                    overlap    <= 1'b0;
                    // A tick taken here merges with one arriving on the same edge.
                    if (tick_pend) begin
                        tick_pend <= 1'b0;
                        if (!gameover) state <= MOVE;
                    end else if (hit_req) begin
                        op_hit    <= 1'b1;
                        req_ascii <= hit_ascii;
                        if (gameover) begin
                            hit_ack   <= 1'b1;
                            hit_found <= 1'b0;
                            state     <= ACK;
                        end else begin
                            state <= HIT;
                        end
                    end else if (spawn_req) begin
                        op_hit    <= 1'b0;
                        req_ascii <= spawn_ascii;
                        req_x     <= spawn_x;
                        req_speed <= spawn_speed;
                        if (gameover) begin
                            spawn_ack <= 1'b1;
                            spawn_ok  <= 1'b0;
                            state     <= ACK;
                        end else begin
                            state <= SPAWN;
                        end
                    end
                end
                MOVE: begin
                    if (slot_valid[idx] && !gameover) begin
                        if (ny >= 11'(BOTTOM)) begin
                            slot_valid[idx] <= 1'b0;
                            slot_ascii[idx] <= '0;
                            slot_x[idx]     <= '0;
                            slot_y[idx]     <= '0;
                            slot_speed[idx] <= '0;
                            miss_cnt        <= miss_inc;
                            if (miss_inc == SCORE_W'(MAX_MISS)) gameover <= 1'b1;
                        end else begin
                            slot_y[idx] <= ny[9:0];
                        end
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(NSLOT - 1)) state <= IDLE;
                end
                HIT: begin
                    // Strict compare keeps the lowest index on equal rows.
                    if (slot_valid[idx] && slot_ascii[idx] == req_ascii &&
                        (!cand_found || slot_y[idx] > cand_y)) begin
                        cand_found <= 1'b1;
                        cand_idx   <= idx;
                        cand_y     <= slot_y[idx];
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(NSLOT - 1)) state <= COMMIT;
                end
                SPAWN: begin
                    if (!slot_valid[idx] && !cand_found) begin
                        cand_found <= 1'b1;
                        cand_idx   <= idx;
                    end
                    if (slot_valid[idx] && slot_x[idx] == req_x && slot_y[idx] < 10'd16)
                        overlap <= 1'b1;
                    idx <= idx + IW'(1);
                    if (idx == IW'(NSLOT - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    if (op_hit) begin
                        hit_ack   <= 1'b1;
                        hit_found <= cand_found;
                        if (cand_found) begin
                            slot_valid[cand_idx] <= 1'b0;
                            slot_ascii[cand_idx] <= '0;
                            slot_x[cand_idx]     <= '0;
                            slot_y[cand_idx]     <= '0;
                            slot_speed[cand_idx] <= '0;
                            score                <= score_inc;
                        end
                    end else begin
                        spawn_ack <= 1'b1;
                        spawn_ok  <= spawn_fits;
                        if (spawn_fits) begin
                            slot_valid[cand_idx] <= 1'b1;
                            slot_ascii[cand_idx] <= req_ascii;
                            slot_x[cand_idx]     <= req_x;
                            slot_y[cand_idx]     <= '0;
                            slot_speed[cand_idx] <= req_speed;
                        end
                    end
                    state <= ACK;
                end
                ACK: begin
                    // Requester is still holding req this cycle; it is ignored.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_slot_sched.sv
// Directed bench for char_slot_sched: spawn/move/hit/overlap/miss/gameover,
// tick merging and reset during a scan, checked against hand-computed values.
`timescale 1ns/1ps
module tb_char_slot_sched;

    logic       pclk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       spawn_req;
    logic [7:0] spawn_ascii;
    logic [9:0] spawn_x;
    logic [2:0] spawn_speed;
    logic       spawn_ack;
    logic       spawn_ok;
    logic       hit_req;
    logic [7:0] hit_ascii;
    logic       hit_ack;
    logic       hit_found;
    logic [3:0] rd_idx;
    logic       rd_valid;
    logic [7:0] rd_ascii;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [2:0] rd_speed;
    logic [9:0] score;
    logic [9:0] miss_cnt;
    logic       gameover;
    logic       tick_drop;

    int n_checks = 0;
    int n_pass   = 0;

    char_slot_sched dut (
        .pclk(pclk), .reset(reset), .frame_tick(frame_tick),
        .spawn_req(spawn_req), .spawn_ascii(spawn_ascii), .spawn_x(spawn_x),
        .spawn_speed(spawn_speed), .spawn_ack(spawn_ack), .spawn_ok(spawn_ok),
        .hit_req(hit_req), .hit_ascii(hit_ascii), .hit_ack(hit_ack), .hit_found(hit_found),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ascii(rd_ascii), .rd_x(rd_x),
        .rd_y(rd_y), .rd_speed(rd_speed), .score(score), .miss_cnt(miss_cnt),
        .gameover(gameover), .tick_drop(tick_drop)
    );

    // Clock / reset
    always #20 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic apply_reset();
        @(negedge pclk);
        reset = 1'b1;
        frame_tick = 1'b0; spawn_req = 1'b0; hit_req = 1'b0;
        spawn_ascii = '0; spawn_x = '0; spawn_speed = '0; hit_ascii = '0; rd_idx = '0;
        repeat (2) @(negedge pclk);
        reset = 1'b0;
    endtask

    // Drivers
    task automatic do_spawn(input logic [7:0] a, input logic [9:0] x, input logic [2:0] s,
                            input int tick_at, output logic ok, output int lat);
        @(negedge pclk);
        spawn_req = 1'b1; spawn_ascii = a; spawn_x = x; spawn_speed = s;
        ok = 1'b0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge pclk);
            frame_tick = (tick_at > 0 && (i == tick_at || i == tick_at + 3));
            if (spawn_ack) begin
                ok = spawn_ok; lat = i;
                break;
            end
        end
        spawn_req = 1'b0; frame_tick = 1'b0;
        if (lat == 0) check("spawn_ack_timeout", 0, 1);
    endtask

    task automatic do_hit(input logic [7:0] a, output logic found, output int lat);
        @(negedge pclk);
        hit_req = 1'b1; hit_ascii = a;
        found = 1'b0; lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge pclk);
            if (hit_ack) begin
                found = hit_found; lat = i;
                break;
            end
        end
        hit_req = 1'b0;
        if (lat == 0) check("hit_ack_timeout", 0, 1);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk); frame_tick = 1'b1;
            @(negedge pclk); frame_tick = 1'b0;
            repeat (20) @(negedge pclk);
        end
    endtask

    task automatic peek(input int i);
        rd_idx = 4'(i);
        #1;
    endtask

    initial begin
        logic ok;
        logic found;
        int   lat;
        int   ok_cnt;
        logic seen_ack;

        // Reset state and basic spawn/move
        apply_reset();
        check("rst_score", score, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_gameover", gameover, 0);
        check("rst_tick_drop", tick_drop, 0);
        check("rst_spawn_ack", spawn_ack, 0);
        check("rst_hit_ack", hit_ack, 0);
        peek(0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_y", rd_y, 0);

        do_spawn(8'h41, 10'd100, 3'd2, 0, ok, lat);
        check("a_spawn_ok", ok, 1);
        check("a_spawn_lat", lat, 18);
        do_ticks(3);
        peek(0);
        check("a_valid", rd_valid, 1);
        check("a_ascii", rd_ascii, 8'h41);
        check("a_x", rd_x, 100);
        check("a_y", rd_y, 6);
        check("a_speed", rd_speed, 2);

        // Fill the table; the 17th spawn is dropped
        apply_reset();
        ok_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            do_spawn(8'(8'h61 + i), 10'(i * 20), 3'd1, 0, ok, lat);
            if (ok) ok_cnt++;
        end
        check("fill_ok_count", ok_cnt, 16);
        do_spawn(8'h7a, 10'd500, 3'd1, 0, ok, lat);
        check("full_spawn_ok", ok, 0);
        check("full_spawn_lat", lat, 18);
        peek(15);
        check("full_s15_x", rd_x, 300);
        check("full_s15_ascii", rd_ascii, 8'h70);
        peek(0);
        check("full_s0_x", rd_x, 0);
        check("full_s0_ascii", rd_ascii, 8'h61);

        // Hit picks the lowest-on-screen match; ties go to the lowest index
        apply_reset();
        do_spawn(8'h42, 10'd0, 3'd2, 0, ok, lat);
        do_ticks(2);
        do_spawn(8'h59, 10'd20, 3'd0, 0, ok, lat);
        do_spawn(8'h59, 10'd40, 3'd0, 0, ok, lat);
        do_spawn(8'h42, 10'd60, 3'd5, 0, ok, lat);
        do_ticks(18);
        peek(0);
        check("hit_s0_y", rd_y, 40);
        peek(3);
        check("hit_s3_y", rd_y, 90);
        do_hit(8'h42, found, lat);
        check("hit_b_found", found, 1);
        check("hit_b_lat", lat, 18);
        peek(3);
        check("hit_s3_cleared", rd_valid, 0);
        peek(0);
        check("hit_s0_kept", rd_valid, 1);
        check("hit_score1", score, 1);
        do_hit(8'h43, found, lat);
        check("hit_c_found", found, 0);
        check("hit_c_score", score, 1);
        do_hit(8'h59, found, lat);
        check("hit_y_found", found, 1);
        peek(1);
        check("hit_tie_s1_cleared", rd_valid, 0);
        peek(2);
        check("hit_tie_s2_kept", rd_valid, 1);
        check("hit_score2", score, 2);

        // Glyph overlap at the same column until the first character reaches row 16
        apply_reset();
        do_spawn(8'h4f, 10'd200, 3'd2, 0, ok, lat);
        check("ovl_first_ok", ok, 1);
        do_spawn(8'h50, 10'd200, 3'd2, 0, ok, lat);
        check("ovl_y0_rejected", ok, 0);
        do_ticks(7);
        do_spawn(8'h50, 10'd200, 3'd2, 0, ok, lat);
        check("ovl_y14_rejected", ok, 0);
        do_ticks(1);
        do_spawn(8'h50, 10'd200, 3'd2, 0, ok, lat);
        check("ovl_y16_accepted", ok, 1);
        peek(0);
        check("ovl_s0_y", rd_y, 16);
        peek(1);
        check("ovl_s1_valid", rd_valid, 1);
        check("ovl_s1_y", rd_y, 0);

        // Misses at the bottom row and game over
        apply_reset();
        do_spawn(8'h4d, 10'd0, 3'd7, 0, ok, lat);
        do_ticks(68);
        peek(0);
        check("miss_y476_valid", rd_valid, 1);
        check("miss_y476", rd_y, 476);
        check("miss_before", miss_cnt, 0);
        do_ticks(1);
        check("miss_invalidated", rd_valid, 0);
        check("miss_one", miss_cnt, 1);
        for (int i = 0; i < 7; i++) do_spawn(8'h4d, 10'(i * 20), 3'd7, 0, ok, lat);
        do_ticks(68);
        check("miss_still_one", miss_cnt, 1);
        check("go_not_yet", gameover, 0);
        do_ticks(1);
        check("miss_eight", miss_cnt, 8);
        check("go_set", gameover, 1);
        do_spawn(8'h4d, 10'd300, 3'd1, 0, ok, lat);
        check("go_spawn_ok", ok, 0);
        check("go_spawn_lat", lat, 1);
        do_hit(8'h4d, found, lat);
        check("go_hit_found", found, 0);
        check("go_hit_lat", lat, 1);
        do_ticks(1);
        peek(0);
        check("go_frozen_valid", rd_valid, 0);
        check("go_frozen_miss", miss_cnt, 8);

        // Two ticks during a spawn merge into one move
        apply_reset();
        do_spawn(8'h54, 10'd0, 3'd3, 3, ok, lat);
        check("drop_spawn_ok", ok, 1);
        repeat (25) @(negedge pclk);
        peek(0);
        check("drop_one_move_y", rd_y, 3);
        check("drop_flag", tick_drop, 1);

        // Reset in the middle of a hit scan
        apply_reset();
        do_spawn(8'h51, 10'd0, 3'd0, 0, ok, lat);
        @(negedge pclk);
        hit_req = 1'b1; hit_ascii = 8'h51;
        repeat (5) @(negedge pclk);
        #5 reset = 1'b1;
        #1;
        check("mid_rst_hit_ack", hit_ack, 0);
        repeat (2) @(negedge pclk);
        hit_req = 1'b0;
        reset = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge pclk);
            if (hit_ack) seen_ack = 1'b1;
        end
        check("mid_rst_no_ack", seen_ack, 0);
        check("mid_rst_score", score, 0);
        peek(0);
        check("mid_rst_s0_cleared", rd_valid, 0);
        do_spawn(8'h52, 10'd10, 3'd1, 0, ok, lat);
        check("mid_rst_spawn_ok", ok, 1);
        check("mid_rst_spawn_lat", lat, 18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
